// File: rtl/adder_serial.sv
`default_nettype none
// ============================================================================
// Module   : adder_serial (with leaf cell adder_1)
// Purpose  : Bit-serial N-bit adder. One full-adder cell is reused over N
//            cycles, LSB first, with a clocked carry and operand/result
//            shift registers. Valid/ready handshake on both sides.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            i_valid/i_ready - operand handshake (a, b, c_in sampled on accept)
//            o_valid/o_ready - result handshake
//            a, b, c_in      - operands and carry into bit 0
//            sum, c_out      - low N bits of a+b+c_in, carry out of bit N-1
//            overflow        - signed overflow (carry into MSB ^ carry out)
//            sub             - only with ADDER_SERIAL_SUB_EN: 1 selects a-b
// Options  : `define ADDER_SERIAL_SUB_EN adds the sub port (a - b support).
// Revision : 1.0 - initial release
// ============================================================================

module adder_1 (
    input  wire logic i_a,
    input  wire logic i_b,
    input  wire logic i_c,
    output logic      o_s,
    output logic      o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module adder_serial #(
    parameter int N = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         i_valid,
    output logic              i_ready,
    input  wire logic [N-1:0] a,
    input  wire logic [N-1:0] b,
    input  wire logic         c_in,
`ifdef ADDER_SERIAL_SUB_EN
    input  wire logic         sub,
`endif
    output logic              o_valid,
    input  wire logic         o_ready,
    output logic [N-1:0]      sum,
    output logic              c_out,
    output logic              overflow
);

    localparam int                 c_CNT_W = $clog2(N + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(N - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [N-1:0]       r_a_sh;
    logic [N-1:0]       r_b_sh;
    logic [N-1:0]       r_sum_sh;
    logic [N-1:0]       w_sum_sh_nxt;
    logic               r_carry;
    logic               r_carry_msb;
    logic [c_CNT_W-1:0] r_count;
    logic               w_cell_sum;
    logic               w_cell_cout;
    logic               w_last;
    logic [N-1:0]       w_b_load;
    logic               w_carry_load;

    // Subtraction is a + ~b + 1, so it reuses the same serial datapath.
`ifdef ADDER_SERIAL_SUB_EN
    assign w_b_load     = sub ? ~b : b;
    assign w_carry_load = sub ? 1'b1 : c_in;
`else
    assign w_b_load     = b;
    assign w_carry_load = c_in;
`endif

    adder_1 u_cell (
        .i_a (r_a_sh[0]),
        .i_b (r_b_sh[0]),
        .i_c (r_carry),
        .o_s (w_cell_sum),
        .o_c (w_cell_cout)
    );

    // New sum bits enter at the MSB so after N shifts bit 0 sits at [0].
    generate
        if (N == 1) begin : g_sum_n1
            assign w_sum_sh_nxt = w_cell_sum;
        end else begin : g_sum_wide
            assign w_sum_sh_nxt = {w_cell_sum, r_sum_sh[N-1:1]};
        end
    endgenerate

    assign w_last = (r_count == c_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_valid) w_state_nxt = S_BUSY;
            S_BUSY:  if (w_last)  w_state_nxt = S_DONE;
            S_DONE:  if (o_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_sum_sh    <= '0;
            r_carry     <= 1'b0;
            r_carry_msb <= 1'b0;
            r_count     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_a_sh   <= a;
                        r_b_sh   <= w_b_load;
                        r_carry  <= w_carry_load;
                        r_sum_sh <= '0;
                        r_count  <= '0;
                    end
                end
                S_BUSY: begin
                    r_sum_sh <= w_sum_sh_nxt;
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_carry  <= w_cell_cout;
                    if (w_last) begin
                        // Carry entering the MSB, needed for signed overflow.
                        r_carry_msb <= r_carry;
                    end else begin
                        r_count <= r_count + c_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign i_ready  = (r_state == S_IDLE);
    assign o_valid  = (r_state == S_DONE);
    assign sum      = r_sum_sh;
    assign c_out    = r_carry;
    assign overflow = r_carry_msb ^ r_carry;

endmodule
`default_nettype wire
